sram_controller: RTL and testbench

Sequences the pipeline's MEM-stage data accesses onto an external 16-bit asynchronous SRAM. Each 32-bit load or store is split into two half-word phases of fixed length. While an access is in flight, `ready` is held low so the top level can freeze every pipeline stage (`freeze = ~ready`). The block sits between the MEM stage (request side) and the board SRAM pins, replacing the single-cycle data memory.

---
 rtl/sram_pkg.sv | 16 +
 rtl/sram_controller.sv | 134 +++++++++++++
 tb/tb_sram_controller.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_pkg.sv
// Shared constants and state encoding for the external 16-bit SRAM controller.
package sram_pkg;

  localparam int unsigned LEN_SRAM_DATA        = 16;
  localparam int unsigned DEFAULT_BASE_ADDR    = 1024;
  localparam int unsigned DEFAULT_PHASE_CYCLES = 3;
  localparam int unsigned DEFAULT_SRAM_ADDR_W  = 18;

  // Plain two-bit constants keep the encoding stable for older tools and scripts.
  typedef logic [1:0] state_t;
  localparam state_t StIdle = 2'd0;
  localparam state_t StLow  = 2'd1;
  localparam state_t StHigh = 2'd2;
  localparam state_t StDone = 2'd3;

endpackage

// File: rtl/sram_controller.sv
// MEM-stage data memory replacement: each 32-bit load/store becomes two fixed-length
// half-word phases on an asynchronous 16-bit SRAM, with ready low while the access runs.
module sram_controller
  import sram_pkg::*;
#(
  parameter int unsigned BASE_ADDR    = DEFAULT_BASE_ADDR,
  parameter int unsigned PHASE_CYCLES = DEFAULT_PHASE_CYCLES,
  parameter int unsigned SRAM_ADDR_W  = DEFAULT_SRAM_ADDR_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic                     rd_en,
  input  logic [31:0]              address,
  input  logic [31:0]              write_data,
  output logic [31:0]              read_data,
  output logic                     ready,
  inout  wire  [LEN_SRAM_DATA-1:0] SRAM_DQ,
  output logic [SRAM_ADDR_W-1:0]   SRAM_ADDR,
  output logic                     SRAM_WE_N,
  output logic                     SRAM_OE_N,
  output logic                     SRAM_CE_N,
  output logic                     SRAM_UB_N,
  output logic                     SRAM_LB_N
);

  state_t                   state_q, state_d;
  logic [3:0]               cnt_q;
  logic                     op_wr_q;
  logic [31:0]              addr_q;
  logic [31:0]              wdata_q;
  logic [LEN_SRAM_DATA-1:0] shadow_q;

  logic                     req;
  logic                     last;
  logic                     active;
  logic                     high;
  logic [31:0]              offset;
  logic [SRAM_ADDR_W-2:0]   idx;
  logic [LEN_SRAM_DATA-1:0] dq_out;

  assign req  = wr_en | rd_en;
  assign last = (cnt_q == 4'(PHASE_CYCLES - 1));

  // Next state: two timed phases, then a single DONE cycle that ignores held requests.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (req) state_d = StLow;
      StLow:   if (last) state_d = StHigh;
      StHigh:  if (last) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State, phase counter, latched request and read-data capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      op_wr_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      shadow_q  <= '0;
      read_data <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        StIdle: begin
          if (req) begin
            // Write wins when both enables are raised together.
            op_wr_q <= wr_en;
            addr_q  <= address;
            wdata_q <= write_data;
            cnt_q   <= '0;
          end
        end
        StLow: begin
          if (last) begin
            cnt_q <= '0;
            if (!op_wr_q) shadow_q <= SRAM_DQ;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        StHigh: begin
          if (last) begin
            cnt_q <= '0;
            // Both halves land together so the pipeline never sees a torn word.
            if (!op_wr_q) read_data <= {SRAM_DQ, shadow_q};
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        default: cnt_q <= '0;
      endcase
    end
  end

  // Word index relative to the mapped base; addresses below the base simply wrap.
  assign offset = addr_q - BASE_ADDR;
  assign idx    = offset[SRAM_ADDR_W:2];

  // Bus strobes and data drive; reset releases the bus immediately, not on the next edge.
  always_comb begin
    active    = !rst && ((state_q == StLow) || (state_q == StHigh));
    high      = (state_q == StHigh);
    SRAM_ADDR = {idx, high};
    SRAM_WE_N = !(active && op_wr_q);
    SRAM_OE_N = !(active && !op_wr_q);
    SRAM_CE_N = !active;
    SRAM_UB_N = !active;
    SRAM_LB_N = !active;
    dq_out    = high ? wdata_q[31:16] : wdata_q[15:0];
  end

  assign SRAM_DQ = (active && op_wr_q) ? dq_out : {LEN_SRAM_DATA{1'bz}};

  // Freeze the pipeline from the request cycle until DONE; reset forces ready high.
  always_comb begin
    ready = 1'b0;
    if (rst) begin
      ready = 1'b1;
    end else begin
      case (state_q)
        StIdle:  ready = !req;
        StDone:  ready = 1'b1;
        default: ready = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller: per-cycle expectations are queued by the stimulus
// and checked by an independent monitor on the falling edge; a behavioural SRAM sits on the bus.
module tb_sram_controller;

  localparam int P = 3;
  localparam logic [15:0] REL = 16'hFFFF;  // value of the pulled-up bus when nobody drives

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  wire  [15:0] dq;
  logic [17:0] sram_addr;
  logic        we_n, oe_n, ce_n, ub_n, lb_n;

  sram_controller #(
    .BASE_ADDR   (1024),
    .PHASE_CYCLES(P),
    .SRAM_ADDR_W (18)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .rd_en     (rd_en),
    .address   (address),
    .write_data(write_data),
    .read_data (read_data),
    .ready     (ready),
    .SRAM_DQ   (dq),
    .SRAM_ADDR (sram_addr),
    .SRAM_WE_N (we_n),
    .SRAM_OE_N (oe_n),
    .SRAM_CE_N (ce_n),
    .SRAM_UB_N (ub_n),
    .SRAM_LB_N (lb_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar i = 0; i < 16; i++) begin : g_pu
    pullup (dq[i]);
  end

  // Behavioural SRAM: combinational read, write captured while WE_N is low.
  logic [15:0] mem [0:(1<<18)-1];
  logic        pl_en;
  logic [17:0] pl_a;
  logic [15:0] pl_v;

  assign dq = (!oe_n && !ce_n) ? mem[sram_addr] : 16'hzzzz;

  always @(posedge clk) begin
    if (pl_en) mem[pl_a] <= pl_v;
    else if (!we_n && !ce_n) mem[sram_addr] <= dq;
  end

  typedef struct packed {
    logic        is_mem;
    logic        rdy;
    logic        we_n;
    logic        oe_n;
    logic        ce_n;
    logic        chk_a;
    logic [17:0] a;
    logic [15:0] dq;
    logic        chk_rd;
    logic [31:0] rd;
    logic [17:0] ma;
    logic [15:0] mv;
  } exp_t;

  exp_t  q [$];
  string q_tag [$];
  int    total = 0;
  int    bad = 0;
  exp_t  me;
  string mtag;
  logic  ok;

  function automatic exp_t ex(input logic rdy, input logic w, input logic o, input logic c,
                              input logic ca, input logic [17:0] a, input logic [15:0] d,
                              input logic cr, input logic [31:0] rd);
    exp_t e;
    e        = '0;
    e.rdy    = rdy;
    e.we_n   = w;
    e.oe_n   = o;
    e.ce_n   = c;
    e.chk_a  = ca;
    e.a      = a;
    e.dq     = d;
    e.chk_rd = cr;
    e.rd     = rd;
    return e;
  endfunction

  task automatic push(input string tag, input exp_t e);
    q.push_back(e);
    q_tag.push_back(tag);
  endtask

  task automatic push_mem(input string tag, input logic [17:0] a, input logic [15:0] v);
    exp_t e;
    e        = '0;
    e.is_mem = 1'b1;
    e.ma     = a;
    e.mv     = v;
    push(tag, e);
  endtask

  task automatic step(input logic r, input logic w, input logic rr, input logic [31:0] a,
                      input logic [31:0] wd, input string tag, input exp_t e);
    rst        = r;
    wr_en      = w;
    rd_en      = rr;
    address    = a;
    write_data = wd;
    push(tag, e);
    @(posedge clk);
    #1;
  endtask

  // One full access; inputs are scrambled after cycle 0 to prove they were latched.
  task automatic access(input string tag, input logic w, input logic r, input logic [31:0] a,
                        input logic [31:0] wd, input logic [17:0] ha, input logic [15:0] lo,
                        input logic [15:0] hi, input logic [31:0] rd0, input logic [31:0] rd1,
                        input bit hold, input int rst_at);
    logic is_w;
    logic en_w, en_r;
    logic [31:0] aa, dd;
    is_w = w;
    for (int c = 0; c <= 2 * P + 1; c++) begin
      if (c == rst_at) begin
        step(1'b1, w, r, a, wd, $sformatf("%s_rst", tag),
             ex(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, '0, REL, 1'b0, '0));
        step(1'b0, 1'b0, 1'b0, a, wd, $sformatf("%s_after_rst", tag),
             ex(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, '0, REL, 1'b1, 32'h0));
        return;
      end
      aa   = (c == 0) ? a : a ^ 32'h0000_0ff0;
      dd   = (c == 0) ? wd : ~wd;
      en_w = (c <= 2 * P || hold) ? w : 1'b0;
      en_r = (c <= 2 * P || hold) ? r : 1'b0;
      if (c == 0)
        step(1'b0, en_w, en_r, aa, dd, $sformatf("%s_c%0d", tag, c),
             ex(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, '0, REL, 1'b1, rd0));
      else if (c <= P)
        step(1'b0, en_w, en_r, aa, dd, $sformatf("%s_c%0d", tag, c),
             ex(1'b0, !is_w, is_w, 1'b0, 1'b1, ha, lo, 1'b1, rd0));
      else if (c <= 2 * P)
        step(1'b0, en_w, en_r, aa, dd, $sformatf("%s_c%0d", tag, c),
             ex(1'b0, !is_w, is_w, 1'b0, 1'b1, ha + 18'd1, hi, 1'b1, rd0));
      else
        step(1'b0, en_w, en_r, aa, dd, $sformatf("%s_c%0d", tag, c),
             ex(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, '0, REL, 1'b1, rd1));
    end
  endtask

  // Monitor: pops one expectation per falling edge and compares against the live outputs.
  always @(negedge clk) begin
    if (q.size() != 0) begin
      me   = q.pop_front();
      mtag = q_tag.pop_front();
      total++;
      if (me.is_mem) begin
        if (mem[me.ma] !== me.mv) begin
          bad++;
          $display("FAIL %s: mem[%0d] got %h want %h", mtag, me.ma, mem[me.ma], me.mv);
        end
      end else begin
        ok = (ready === me.rdy) && (we_n === me.we_n) && (oe_n === me.oe_n) &&
             (ce_n === me.ce_n) && (ub_n === me.ce_n) && (lb_n === me.ce_n) &&
             (dq === me.dq) && (!me.chk_a || sram_addr === me.a) &&
             (!me.chk_rd || read_data === me.rd);
        if (!ok) begin
          bad++;
          $display({"FAIL %s: got rdy=%b we=%b oe=%b ce=%b ub=%b lb=%b a=%0d dq=%h rd=%h; ",
                    "want rdy=%b we=%b oe=%b ce=%b a=%0d(chk %b) dq=%h rd=%h(chk %b)"},
                   mtag, ready, we_n, oe_n, ce_n, ub_n, lb_n, sram_addr, dq, read_data,
                   me.rdy, me.we_n, me.oe_n, me.ce_n, me.a, me.chk_a, me.dq, me.rd, me.chk_rd);
        end
      end
    end
  end

  initial begin
    rst        = 1'b1;
    wr_en      = 1'b0;
    rd_en      = 1'b0;
    address    = '0;
    write_data = '0;
    pl_en      = 1'b0;
    pl_a       = '0;
    pl_v       = '0;
    @(posedge clk);
    #1;

    step(1'b1, 1'b0, 1'b0, '0, '0, "reset0", ex(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, '0, REL, 1'b1, 0));
    step(1'b1, 1'b0, 1'b0, '0, '0, "reset1", ex(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, '0, REL, 1'b1, 0));
    step(1'b0, 1'b0, 1'b0, '0, '0, "idle0", ex(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, '0, REL, 1'b1, 0));

    access("st1024", 1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 18'd0, 16'hBEEF, 16'hDEAD,
           32'h0, 32'h0, 1'b0, -1);
    access("ld1024", 1'b0, 1'b1, 32'd1024, 32'h0, 18'd0, 16'hBEEF, 16'hDEAD,
           32'h0, 32'hDEADBEEF, 1'b0, -1);
    access("st1028", 1'b1, 1'b0, 32'd1028, 32'h12345678, 18'd2, 16'h5678, 16'h1234,
           32'hDEADBEEF, 32'hDEADBEEF, 1'b1, -1);
    access("ld1028", 1'b0, 1'b1, 32'd1028, 32'h0, 18'd2, 16'h5678, 16'h1234,
           32'hDEADBEEF, 32'h12345678, 1'b0, -1);
    access("both1032", 1'b1, 1'b1, 32'd1032, 32'h0000CAFE, 18'd4, 16'hCAFE, 16'h0000,
           32'h12345678, 32'h12345678, 1'b0, -1);

    // Seed the target words so a partial write shows up.
    pl_en = 1'b1;
    pl_a  = 18'd8;
    pl_v  = 16'h1111;
    step(1'b0, 1'b0, 1'b0, '0, '0, "seed8",
         ex(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, '0, REL, 1'b1, 32'h12345678));
    pl_a  = 18'd9;
    step(1'b0, 1'b0, 1'b0, '0, '0, "seed9",
         ex(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, '0, REL, 1'b1, 32'h12345678));
    pl_en = 1'b0;

    access("st1040", 1'b1, 1'b0, 32'd1040, 32'hAAAA5555, 18'd8, 16'h5555, 16'hAAAA,
           32'h12345678, 32'h12345678, 1'b0, 4);

    push_mem("mem0", 18'd0, 16'hBEEF);
    push_mem("mem1", 18'd1, 16'hDEAD);
    push_mem("mem2", 18'd2, 16'h5678);
    push_mem("mem3", 18'd3, 16'h1234);
    push_mem("mem4", 18'd4, 16'hCAFE);
    push_mem("mem5", 18'd5, 16'h0000);
    push_mem("mem8", 18'd8, 16'h5555);
    push_mem("mem9", 18'd9, 16'h1111);

    rst   = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    repeat (12) @(posedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
